// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, counter widths and hex segment table for the seven-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int REFRESH_DIV_DEFAULT  = 100000;
    localparam int BLINK_FRAMES_DEFAULT = 64;

    // Width of a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int TICK_W  = cnt_width(REFRESH_DIV_DEFAULT);
    localparam int BLINK_W = cnt_width(BLINK_FRAMES_DEFAULT);

    // Active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low seven-segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment driver with shadowed word capture and per-digit blink
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int TW = cnt_width(REFRESH_DIV);
    localparam int BW = cnt_width(BLINK_FRAMES);
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   shadow;
    logic          full;
    logic [BW-1:0] blink_cnt;
    logic          phase_on;

    logic          tick_last;
    logic          frame_end;
    logic          accept;
    logic          blank;
    logic [3:0]    nibble;
    logic [6:0]    dec_seg;

    assign tick_last = (tick == TICK_LAST);
    assign frame_end = tick_last && (idx == 2'd3);
    assign accept    = in_valid && !full;
    assign in_ready  = !full;
    assign blank     = blink_mask[idx] && !phase_on;

    always_comb begin
        nibble = disp[3:0];
        case (idx)
            2'd0: nibble = disp[3:0];
            2'd1: nibble = disp[7:4];
            2'd2: nibble = disp[11:8];
            default: nibble = disp[15:12];
        endcase
    end

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick       <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            shadow     <= 16'h0000;
            full       <= 1'b0;
            blink_cnt  <= '0;
            phase_on   <= 1'b1;
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tick <= tick_last ? '0 : tick + 1'b1;
            if (tick_last)
                idx <= idx + 2'd1;

            // The display word only changes at a frame boundary, so a frame never mixes two words.
            if (frame_end && full) begin
                disp <= shadow;
                full <= 1'b0;
            end else if (accept) begin
                shadow <= in_data;
                full   <= 1'b1;
            end

            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase_on  <= !phase_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            an         <= ~(4'b0001 << idx);
            seg        <= blank ? SEG_BLANK : dec_seg;
            dp         <= blank ? 1'b1 : ~dp_mask[idx];
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver with a cycle scoreboard
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       rdy;
    } obs_t;

    obs_t sb[$];
    int total = 0;
    int bad = 0;
    int cycnt = 0;

    logic [6:0] hex_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_shadow = 16'h0000;
    logic        m_full = 1'b0;
    int          m_bcnt = 0;
    logic        m_phase = 1'b1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: reference model predicts the registered outputs, DUT is sampled 1 time unit after the edge.
    task automatic cyc();
        obs_t e;
        obs_t o;
        logic boundary;
        logic blank;
        logic [3:0] nib;
        @(posedge clk);
        cycnt++;
        if (!rst_n) begin
            m_cnt = 0; m_idx = 0; m_disp = 16'h0000; m_full = 1'b0;
            m_bcnt = 0; m_phase = 1'b1;
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, rdy: 1'b1};
        end else begin
            nib      = 4'((m_disp >> (4 * m_idx)) & 16'hF);
            blank    = blink_mask[m_idx] && !m_phase;
            boundary = (m_cnt == 3) && (m_idx == 3);
            e.an  = ~(4'b0001 << m_idx);
            e.seg = blank ? 7'h7F : hex_tb[nib];
            e.dp  = blank ? 1'b1 : ~dp_mask[m_idx];
            e.fd  = boundary;
            if (boundary && m_full) begin
                m_disp = m_shadow;
                m_full = 1'b0;
            end else if (in_valid && !m_full) begin
                m_shadow = in_data;
                m_full = 1'b1;
            end
            if (boundary) begin
                if (m_bcnt == 1) begin
                    m_bcnt = 0;
                    m_phase = !m_phase;
                end else begin
                    m_bcnt++;
                end
            end
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            e.rdy = !m_full;
        end
        sb.push_back(e);
        #1;
        o = '{an: an, seg: seg, dp: dp, fd: frame_done, rdy: in_ready};
        e = sb.pop_front();
        chk($sformatf("scoreboard_cycle%0d", cycnt), 32'(o), 32'(e));
    endtask

    function automatic int zeros(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    initial begin
        int n;
        logic got_fd;
        logic seen_on;
        logic seen_off;

        // Reset
        for (int i = 0; i < 3; i++) cyc();
        chk("reset_an", 32'(an), 32'h0000000F);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_ready", 32'(in_ready), 32'h1);
        chk("reset_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("scan_onehot", 32'(zeros(an)), 32'd1);
            chk("scan_zero_digit", 32'(seg), 32'h40);
        end

        // Handshake mid-frame at index 1
        n = 0;
        while (m_idx != 1 && n < 40) begin cyc(); n++; end
        chk("reach_index1", 32'(m_idx), 32'd1);
        in_data = 16'h1A2F; in_valid = 1'b1;
        cyc();
        chk("ready_drop", 32'(in_ready), 32'h0);
        // Backpressure: these words must be ignored
        in_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) cyc();
        in_valid = 1'b0; in_data = 16'h0000;

        got_fd = 1'b0; n = 0;
        while (!got_fd && n < 40) begin
            cyc(); n++;
            chk("no_tear_old_word", 32'(seg), 32'h40);
            got_fd = frame_done;
        end
        chk("fd_seen", 32'(got_fd), 32'h1);
        chk("ready_after_transfer", 32'(in_ready), 32'h1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            case (an)
                4'b1110: chk("word_digit0", 32'(seg), 32'h0E);
                4'b1101: chk("word_digit1", 32'(seg), 32'h24);
                4'b1011: chk("word_digit2", 32'(seg), 32'h08);
                4'b0111: chk("word_digit3", 32'(seg), 32'h79);
                default: chk("word_an_onehot", 32'(an), 32'h0000000E);
            endcase
        end

        // Blink on digit 2
        blink_mask = 4'b0100;
        in_data = 16'h8888; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        got_fd = 1'b0; n = 0;
        while (!got_fd && n < 40) begin cyc(); n++; got_fd = frame_done; end
        chk("blink_load_fd", 32'(got_fd), 32'h1);
        seen_on = 1'b0; seen_off = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            chk("blink_onehot", 32'(zeros(an)), 32'd1);
            if (an == 4'b1011) begin
                if (seg == 7'h00) seen_on = 1'b1;
                if (seg == 7'h7F) seen_off = 1'b1;
            end else if (i > 0) begin
                chk("blink_other_digit", 32'(seg), 32'h00);
            end
        end
        chk("blink_seen_on", 32'(seen_on), 32'h1);
        chk("blink_seen_off", 32'(seen_off), 32'h1);
        blink_mask = 4'b0000;

        // Decimal points and one-hot anodes over 20 frames
        dp_mask = 4'b1001;
        cyc();
        for (int i = 0; i < 320; i++) begin
            cyc();
            chk("dp_onehot", 32'(zeros(an)), 32'd1);
            chk("dp_position", 32'(dp), 32'((an == 4'b1110 || an == 4'b0111) ? 1'b0 : 1'b1));
        end
        dp_mask = 4'b0000;

        // Reset while a word waits in the shadow
        n = 0;
        while (!in_ready && n < 40) begin cyc(); n++; end
        in_data = 16'h5555; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("mid_reset_accept", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_reset_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 48; i++) begin
            cyc();
            chk("post_reset_zero", 32'(seg), 32'h40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
